branch_detector: RTL and testbench

BRANCH_DETECTOR -- requirements
Module: branch_detector

---
 rtl/branch_detector_pkg.sv | 12 +
 rtl/branch_detector_thread_number.sv | 32 +++
 rtl/branch_detector.sv | 101 ++++++++++
 tb/tb_branch_detector.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/branch_detector_pkg.sv
// Shared constants for the branch detector: default Octavo sizing and pipeline shape.
package branch_detector_pkg;

    localparam int DEFAULT_PC_WIDTH           = 10;
    localparam int DEFAULT_THREAD_COUNT       = 8;
    localparam int DEFAULT_THREAD_COUNT_WIDTH = 3;

    // Total latency from pc to branch_reached; stage 0 is the compare stage.
    localparam int PIPE_DEPTH       = 2;
    localparam int THREAD_SLOT_INIT = 0;

endpackage

// File: rtl/branch_detector_thread_number.sv
// Round-robin thread slot counter: advances every cycle and wraps at THREAD_COUNT-1.
module branch_detector_thread_number #(
    parameter int THREAD_COUNT       = 8,
    parameter int THREAD_COUNT_WIDTH = 3,
    parameter int INITIAL_THREAD     = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    output logic [THREAD_COUNT_WIDTH-1:0] thread
);

    logic [THREAD_COUNT_WIDTH-1:0] thread_reg;
    logic [THREAD_COUNT_WIDTH-1:0] thread_next;

    always_comb begin
        thread_next = thread_reg + 1'b1;
        if (thread_reg == THREAD_COUNT_WIDTH'(THREAD_COUNT - 1)) begin
            thread_next = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            thread_reg <= THREAD_COUNT_WIDTH'(INITIAL_THREAD);
        end else begin
            thread_reg <= thread_next;
        end
    end

    assign thread = thread_reg;

endmodule

// File: rtl/branch_detector.sv
// Per-thread branch origin/destination store; flags when a thread's pc hits its enabled origin.
module branch_detector
    import branch_detector_pkg::*;
#(
    parameter int PC_WIDTH           = DEFAULT_PC_WIDTH,
    parameter int THREAD_COUNT       = DEFAULT_THREAD_COUNT,
    parameter int THREAD_COUNT_WIDTH = DEFAULT_THREAD_COUNT_WIDTH
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PC_WIDTH-1:0] pc,
    input  logic                IO_Ready,
    input  logic                IO_Ready_previous,
    input  logic                load_origin,
    input  logic                load_destination,
    input  logic                load_disable,
    input  logic [PC_WIDTH-1:0] load_value,
    output logic                branch_reached,
    output logic                branch_reached_ready,
    output logic [PC_WIDTH-1:0] branch_destination
);

    localparam int STAGE_WIDTH = PC_WIDTH + 2;

    logic [THREAD_COUNT_WIDTH-1:0] slot;
    logic [PC_WIDTH-1:0]           origin_w [THREAD_COUNT];
    logic [PC_WIDTH-1:0]           dest_w   [THREAD_COUNT];
    logic [THREAD_COUNT-1:0]       enable_w;
    logic                          match;
    logic [STAGE_WIDTH-1:0]        stage_in;
    logic [STAGE_WIDTH-1:0]        pipe_reg [PIPE_DEPTH];

    branch_detector_thread_number #(
        .THREAD_COUNT       (THREAD_COUNT),
        .THREAD_COUNT_WIDTH (THREAD_COUNT_WIDTH),
        .INITIAL_THREAD     (THREAD_SLOT_INIT)
    ) u_thread_number (
        .clock  (clock),
        .reset  (reset),
        .thread (slot)
    );

    // Each thread owns its entry; only the thread in the current slot may be written.
    genvar gi;
    generate
        for (gi = 0; gi < THREAD_COUNT; gi++) begin : g_thread
            logic [PC_WIDTH-1:0] origin_reg;
            logic [PC_WIDTH-1:0] dest_reg;
            logic                enable_reg;
            logic                write_en;

            assign write_en = IO_Ready_previous && (slot == THREAD_COUNT_WIDTH'(gi));

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    origin_reg <= '0;
                    dest_reg   <= '0;
                    enable_reg <= 1'b0;
                end else if (write_en) begin
                    if (load_origin) begin
                        origin_reg <= load_value;
                    end
                    if (load_destination) begin
                        dest_reg <= load_value;
                    end
                    if (load_disable) begin
                        enable_reg <= 1'b0;
                    end else if (load_origin) begin
                        enable_reg <= 1'b1;
                    end
                end
            end

            assign origin_w[gi] = origin_reg;
            assign dest_w[gi]   = dest_reg;
            assign enable_w[gi] = enable_reg;
        end
    endgenerate

    // Compare reads the pre-write state, so a same-cycle load shows up on the next pass.
    assign match    = enable_w[slot] && (pc == origin_w[slot]);
    assign stage_in = {match, IO_Ready, dest_w[slot]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                pipe_reg[i] <= '0;
            end
        end else begin
            pipe_reg[0] <= stage_in;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                pipe_reg[i] <= pipe_reg[i-1];
            end
        end
    end

    assign branch_reached       = pipe_reg[PIPE_DEPTH-1][STAGE_WIDTH-1];
    assign branch_reached_ready = pipe_reg[PIPE_DEPTH-1][STAGE_WIDTH-2];
    assign branch_destination   = pipe_reg[PIPE_DEPTH-1][PC_WIDTH-1:0];

endmodule

// File: tb/tb_branch_detector.sv
// Directed bench for branch_detector: each step carries its hand-computed result, checked two cycles later.
module tb_branch_detector;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] pc = '0;
    logic       IO_Ready = 1'b0;
    logic       IO_Ready_previous = 1'b0;
    logic       load_origin = 1'b0;
    logic       load_destination = 1'b0;
    logic       load_disable = 1'b0;
    logic [9:0] load_value = '0;
    logic       branch_reached;
    logic       branch_reached_ready;
    logic [9:0] branch_destination;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Expectations for the last two driven cycles (p1 = previous, p2 = two back).
    logic       p1_v, p1_br, p1_rdy, p1_cd;
    logic [9:0] p1_d;
    logic       p2_v, p2_br, p2_rdy, p2_cd;
    logic [9:0] p2_d;

    branch_detector #(
        .PC_WIDTH           (10),
        .THREAD_COUNT       (8),
        .THREAD_COUNT_WIDTH (3)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .pc                   (pc),
        .IO_Ready             (IO_Ready),
        .IO_Ready_previous    (IO_Ready_previous),
        .load_origin          (load_origin),
        .load_destination     (load_destination),
        .load_disable         (load_disable),
        .load_value           (load_value),
        .branch_reached       (branch_reached),
        .branch_reached_ready (branch_reached_ready),
        .branch_destination   (branch_destination)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic clear_expect();
        p1_v = 1'b1; p1_br = 1'b0; p1_rdy = 1'b0; p1_cd = 1'b1; p1_d = '0;
        p2_v = 1'b1; p2_br = 1'b0; p2_rdy = 1'b0; p2_cd = 1'b1; p2_d = '0;
    endtask

    // Called mid-cycle: check the result of two steps ago, then drive this cycle.
    task automatic step(input logic [9:0] p, input logic rdy, input logic rdyp,
                        input logic lo, input logic ld, input logic ldis,
                        input logic [9:0] lv, input logic eb, input logic cd,
                        input logic [9:0] ed);
        $display("[TB] cyc=%0d slot=%0d pc=%0h lo=%0b ld=%0b ldis=%0b rdyp=%0b lv=%0h -> reached=%0b ready=%0b dest=%0h",
                 cyc, cyc % 8, p, lo, ld, ldis, rdyp, lv,
                 branch_reached, branch_reached_ready, branch_destination);
        if (p2_v) begin
            chk("reached", 32'(branch_reached), 32'(p2_br));
            chk("ready", 32'(branch_reached_ready), 32'(p2_rdy));
            if (p2_cd) chk("dest", 32'(branch_destination), 32'(p2_d));
        end
        p2_v = p1_v; p2_br = p1_br; p2_rdy = p1_rdy; p2_cd = p1_cd; p2_d = p1_d;
        p1_v = 1'b1; p1_br = eb; p1_rdy = rdy; p1_cd = cd; p1_d = ed;
        pc = p; IO_Ready = rdy; IO_Ready_previous = rdyp;
        load_origin = lo; load_destination = ld; load_disable = ldis; load_value = lv;
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic idle();
        step(10'h3FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000);
    endtask

    task automatic goto_slot(input int s);
        for (int i = 0; i < 8 && (cyc % 8) != s; i++) idle();
    endtask

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_reached", 32'(branch_reached), 32'd0);
        chk("rst_ready", 32'(branch_reached_ready), 32'd0);
        chk("rst_dest", 32'(branch_destination), 32'd0);
        reset = 1'b0;
        cyc = 0;
        clear_expect();

        // All enables clear: pc=0 never hits.
        for (int i = 0; i < 20; i++) step(10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h000);

        // Thread 3: origin 0x05A, then destination 0x100 on the following pass.
        goto_slot(3); step(10'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'h05A, 1'b0, 1'b1, 10'h000);
        goto_slot(3); step(10'h000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 10'h100, 1'b0, 1'b1, 10'h000);
        goto_slot(3);
        for (int i = 0; i < 8; i++)
            step(10'h05A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, (i == 0), (i == 0), 10'h100);

        // Loads with IO_Ready_previous=0 are ignored.
        goto_slot(3); step(10'h000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'h077, 1'b0, 1'b1, 10'h100);
        goto_slot(3); step(10'h077, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h100);
        goto_slot(3); step(10'h05A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h100);

        // Thread 5: load_disable beats load_origin.
        goto_slot(5); step(10'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 10'h033, 1'b0, 1'b1, 10'h000);
        goto_slot(5); step(10'h033, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h000);

        // Thread 2: same-cycle load and compare sees the old state.
        goto_slot(2); step(10'h010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'h010, 1'b0, 1'b1, 10'h000);
        goto_slot(2); step(10'h010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h000);

        // Thread 6: joint origin/destination load, then full-width compare edges.
        goto_slot(6); step(10'h000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'h2AB, 1'b0, 1'b1, 10'h000);
        goto_slot(6); step(10'h2AB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h2AB);
        goto_slot(6); step(10'h2AA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h2AB);
        goto_slot(6); step(10'h3AB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h2AB);

        // Thread 7: origin 0 is a legal target once enabled.
        goto_slot(7); step(10'h3FF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h000);
        goto_slot(7); step(10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h000);

        // Thread 3: disable alone, then re-arm.
        goto_slot(3); step(10'h05A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 10'h000, 1'b1, 1'b1, 10'h100);
        goto_slot(3); step(10'h05A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h100);
        goto_slot(3); step(10'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'h05A, 1'b0, 1'b1, 10'h100);
        goto_slot(3); step(10'h05A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h100);
        idle();

        // Outputs currently show the hit; asynchronous reset must clear them at once.
        chk("pre_reset_reached", 32'(branch_reached), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_reached", 32'(branch_reached), 32'd0);
        chk("async_ready", 32'(branch_reached_ready), 32'd0);
        chk("async_dest", 32'(branch_destination), 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        cyc = 0;
        clear_expect();

        for (int i = 0; i < 8; i++)
            step(10'h05A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h000);
        // Slot restarted at 0, so reloading at cyc%8==3 lands on thread 3 again.
        goto_slot(3); step(10'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'h05A, 1'b0, 1'b1, 10'h000);
        goto_slot(3); step(10'h05A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h000);
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
